// File: rtl/cnn_mac_sched.sv
// Dot-product sequencer: streams activation/weight pairs from two memories into a shared
// 2-stage multiplier and accumulates the products. Optional bias preload under CNN_MAC_BIAS_EN.
module cnn_mac_sched #(
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
`ifdef CNN_MAC_BIAS_EN
    input  logic [15:0]       bias,
`endif
    output logic              busy,
    output logic              act_rd,
    output logic [ADDR_W-1:0] act_addr,
    input  logic [15:0]       act_data,
    output logic              wgt_rd,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [7:0]        wgt_data,
    output logic              mul_ce,
    output logic [15:0]       mul_a,
    output logic [7:0]        mul_b,
    input  logic [23:0]       mul_p,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q;
    logic [2:0]        tag_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_init;
    logic [ACC_W-1:0]  prod_ext;
    logic              issuing;
    logic              running;

    assign issuing = (state_q == ISSUE);
    assign running = (state_q == ISSUE) || (state_q == DRAIN);

`ifdef CNN_MAC_BIAS_EN
    // Bias is pre-scaled by 2^8 so it lines up with the 16x8 product fixed-point scale.
    assign acc_init = {{(ACC_W-16){bias[15]}}, bias} << 8;
`else
    assign acc_init = '0;
`endif

    assign prod_ext = {{(ACC_W-24){mul_p[23]}}, mul_p};

    assign busy      = (state_q != IDLE);
    assign act_rd    = issuing;
    assign wgt_rd    = issuing;
    assign act_addr  = addr_q;
    assign wgt_addr  = addr_q;
    assign mul_ce    = running;
    assign mul_a     = running ? act_data : '0;
    assign mul_b     = running ? wgt_data : '0;
    assign res_valid = (state_q == DONE);
    assign res_data  = acc_q;
    assign dbg_state = state_q;

    // Handshake: res_valid/res_data are held until res_valid && res_ready is seen at a
    // rising edge; start is only looked at while IDLE, so it is ignored in the handshake cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            tag_q   <= '0;
            acc_q   <= '0;
        end else begin
            // tag[k] follows a real read k+1 cycles after its address was issued;
            // tag[2] lines up with that read's product on mul_p.
            tag_q <= {tag_q[1:0], issuing};
            if (tag_q[2]) begin
                acc_q <= acc_q + prod_ext;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        addr_q  <= '0;
                        acc_q   <= acc_init;
                        state_q <= (len == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if ({1'b0, addr_q} == len_q - LEN_ONE) begin
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    // tag[2] is consumed on this same edge, so only the younger stages matter.
                    if (tag_q[1:0] == 2'b00) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_mac_sched.sv
// Directed bench for cnn_mac_sched with behavioural memories and a 2-stage multiplier model.
module tb_cnn_mac_sched;

    localparam int ADDR_W = 10;
    localparam int ACC_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic [15:0]       bias = '0;
    logic              busy;
    logic              act_rd;
    logic [ADDR_W-1:0] act_addr;
    logic [15:0]       act_data = '0;
    logic              wgt_rd;
    logic [ADDR_W-1:0] wgt_addr;
    logic [7:0]        wgt_data = '0;
    logic              mul_ce;
    logic [15:0]       mul_a;
    logic [7:0]        mul_b;
    logic [23:0]       mul_p;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [ACC_W-1:0]  res_data;
    logic [1:0]        dbg_state;

    logic signed [15:0] act_mem [1024];
    logic signed [7:0]  wgt_mem [1024];
    logic signed [23:0] p1 = '0;
    logic signed [23:0] p2 = '0;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    logic [ACC_W-1:0] exp_q [$];

    cnn_mac_sched #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
`ifdef CNN_MAC_BIAS_EN
        .bias      (bias),
`endif
        .busy      (busy),
        .act_rd    (act_rd),
        .act_addr  (act_addr),
        .act_data  (act_data),
        .wgt_rd    (wgt_rd),
        .wgt_addr  (wgt_addr),
        .wgt_data  (wgt_data),
        .mul_ce    (mul_ce),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .dbg_state (dbg_state)
    );

    // clock / memories / multiplier model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (act_rd) act_data <= act_mem[act_addr];
        if (wgt_rd) wgt_data <= wgt_mem[wgt_addr];
        if (mul_ce) begin
            p1 <= $signed(mul_a) * $signed(mul_b);
            p2 <= p1;
        end
        if (res_valid && res_ready) hs_cnt <= hs_cnt + 1;
    end
    assign mul_p = p2;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command at the current cycle (cycle 0) and follow it to the result handshake.
    task automatic do_cmd(input int n, input int hold, input logic signed [31:0] exp,
                          input string tag);
        int cyc;
        int hs0;
        exp_q.push_back(exp);
        hs0 = hs_cnt;
        res_ready = (hold == 0);
        start = 1'b1;
        len = (ADDR_W+1)'(n);
        cyc = 0;
        do begin
            tick();
            cyc++;
            start = 1'b0;
            if (n > 0 && n <= 16) begin
                if (cyc <= n) begin
                    check({tag, "_act_rd"}, act_rd, 1);
                    check({tag, "_act_addr"}, act_addr, cyc - 1);
                    check({tag, "_wgt_addr"}, wgt_addr, cyc - 1);
                end else if (cyc <= n + 3) begin
                    check({tag, "_drain_ce"}, mul_ce, 1);
                    check({tag, "_drain_rd"}, act_rd, 0);
                end
            end
        end while (!res_valid && cyc < n + 20);
        check({tag, "_latency"}, cyc, (n == 0) ? 1 : n + 4);
        check({tag, "_data"}, $signed(res_data), $signed(exp_q.pop_front()));
        check({tag, "_busy"}, busy, 1);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                start = (h == 3);
                len = 11'd2;
                tick();
                start = 1'b0;
                check({tag, "_hold_valid"}, res_valid, 1);
                check({tag, "_hold_data"}, $signed(res_data), exp);
            end
            res_ready = 1'b1;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_valid_after"}, res_valid, 0);
        if (hold > 0) begin
            repeat (3) begin
                tick();
                check({tag, "_idle"}, busy, 0);
            end
        end
        check({tag, "_results"}, hs_cnt - hs0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_act_rd"}, act_rd, 0);
        check({tag, "_wgt_rd"}, wgt_rd, 0);
        check({tag, "_addr"}, act_addr, 0);
        check({tag, "_mul_ce"}, mul_ce, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_data"}, res_data, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            act_mem[i] = '0;
            wgt_mem[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset_n = 1'b1;
        tick();

        // basic: 5 - 12 - 21 - 32 = -60
        act_mem[0] = 16'sd1; act_mem[1] = -16'sd2; act_mem[2] = 16'sd3; act_mem[3] = -16'sd4;
        wgt_mem[0] = 8'sd5;  wgt_mem[1] = 8'sd6;   wgt_mem[2] = -8'sd7; wgt_mem[3] = 8'sd8;
        do_cmd(4, 0, -32'sd60, "basic");

        do_cmd(0, 0, 32'sd0, "len0");

        // backpressure: -100 - 400 + 900 = 400
        act_mem[0] = 16'sd100; act_mem[1] = -16'sd200; act_mem[2] = 16'sd300;
        wgt_mem[0] = -8'sd1;   wgt_mem[1] = 8'sd2;     wgt_mem[2] = 8'sd3;
        do_cmd(3, 10, 32'sd400, "bp");

        // reset mid-ISSUE of a 16-element command
        for (int i = 0; i < 16; i++) begin
            act_mem[i] = 16'(1000 + i);
            wgt_mem[i] = 8'(50 - i);
        end
        start = 1'b1;
        len = 11'd16;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_busy", busy, 1);
        check("mid_act_rd", act_rd, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        act_mem[0] = 16'sd7; act_mem[1] = -16'sd9;
        wgt_mem[0] = 8'sd3;  wgt_mem[1] = 8'sd4;
        do_cmd(2, 0, -32'sd15, "post_rst");

        // extremes: 4194304 * 1024 = 2^32 wraps to 0
        for (int i = 0; i < 1024; i++) begin
            act_mem[i] = -16'sd32768;
            wgt_mem[i] = -8'sd128;
        end
        do_cmd(1024, 0, 32'sd0, "wrap1024");
        do_cmd(1023, 0, -32'sd4194304, "wrap1023");

`ifdef CNN_MAC_BIAS_EN
        // -3 * 256 + 10 * 2 = -748
        bias = -16'sd3;
        act_mem[0] = 16'sd10;
        wgt_mem[0] = 8'sd2;
        do_cmd(1, 0, -32'sd748, "bias");
        bias = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_mac_sched.md
# cnn_mac_sched

Sequencer that drives the shared 16×8 signed pipelined multiplier (2-register latency, clock-enable gated) to compute one dot product per command. It reads a 16-bit activation vector and an 8-bit weight vector from two synchronous single-port memories, streams the operand pairs into the multiplier, and accumulates the 24-bit products. It returns the sum over a valid/ready result port. It sits between the convolution/FC layer control and the multiplier instance.

## Interface
- ADDR_W, 10: memory address width; max vector length 2^ADDR_W
- ACC_W, 32: accumulator/result width (≥24)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- len  in  ADDR_W+1  element count N (0..2^ADDR_W), captured with start
- busy  out  1  high from command accept until result handshake
- act_rd / act_addr  out  1 / ADDR_W  activation read enable/address
- act_data  in  16  signed activation; valid the cycle after act_rd
- wgt_rd / wgt_addr  out  1 / ADDR_W  weight read enable/address (same timing as act)
- wgt_data  in  8  signed weight; valid the cycle after wgt_rd
- mul_ce  out  1  multiplier clock enable
- mul_a / mul_b  out  16 / 8  multiplier operands
- mul_p  in  24  signed product; reflects operands presented 2 enabled cycles earlier
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  ACC_W  signed dot product

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1, capture len, clear accumulator (see Configuration), reset address counter. Go to ISSUE if len≠0, else DONE.
- ISSUE: assert act_rd=wgt_rd=1, addresses 0..N-1, one per cycle. After address N-1, go to DRAIN.
- mul_a=act_data and mul_b=wgt_data, combinationally. A 3-bit valid-tag shift register marks which mul_p samples are real products.
- DRAIN: wait until the tag pipeline is empty, then go to DONE.
- mul_ce=1 in ISSUE and DRAIN, 0 in IDLE and DONE.
- Accumulate: acc <= acc + sign-extend(mul_p) when tag[2]=1. Addition is two's complement; it wraps modulo 2^ACC_W with no saturation.
- DONE: res_valid=1, res_data=acc, held stable until res_ready=1. On the handshake, go to IDLE.
- start is ignored while busy=1, including in the handshake cycle. A new command is accepted no earlier than the cycle after the handshake.
- Reset (any time, including mid-ISSUE/DRAIN): state=IDLE, tags and accumulator cleared, command abandoned.

## Timing
- Reset values: busy=0, act_rd=wgt_rd=0, act_addr=wgt_addr=0, mul_ce=0, mul_a/mul_b=0 when not in ISSUE/DRAIN, res_valid=0, res_data=0.
- Cycle 0: start accepted. Cycles 1..N: ISSUE. Last product accumulated at the end of cycle N+3. Cycle N+4: res_valid=1.
- Command latency is N+4 cycles from start to res_valid, then 1 cycle back to IDLE after the handshake.
- len=0: res_valid=1 at cycle 1, with res_data = initial accumulator value.
- busy=1 on cycles 1 through the handshake cycle inclusive.

## Configuration
- CNN_MAC_BIAS_EN defined:
  - Adds input port bias (16, signed), captured with start.
  - Accumulator is initialised to sign-extend(bias) << 8, matching the product fixed-point scale.
- CNN_MAC_BIAS_EN undefined:
  - No bias port.
  - Accumulator is initialised to 0.

## Test plan
- Reset: assert reset_n=0 mid-ISSUE of N=16.
  - All outputs return to their reset values immediately.
  - After release, a new N=2 command gives the correct result with no residue.
- Basic: N=4, act={1,-2,3,-4}, wgt={5,6,-7,8}, res_ready=1.
  - res_data=-60 at cycle 8.
  - busy low at cycle 9.
- Extremes/wrap: N=1024, all act=-32768, wgt=-128, ACC_W=32.
  - Each product is 4194304; the sum 2^32 wraps, so res_data=0.
  - With N=1023: res_data=-4194304.
- Backpressure and ignored start: N=3 with res_ready held 0 for 10 cycles, start pulsed during DONE.
  - res_valid and res_data stay stable throughout.
  - The start pulse is ignored.
  - Exactly one result is delivered.
- len=0: res_valid at cycle 1, res_data=0 without the macro.
- Bias (macro on): bias=-3, N=1, act=10, wgt=2 -> res_data=-748.
